hadd_pulse_tx: RTL
==================

Name: hadd_pulse_tx

Overview:
Pulse-stream transmitter that drives a pulse-based half adder's A_in/B_in/clock inputs from parallel bit-pair symbols.
- Symbols are accepted through a valid/ready handshake into a small FIFO.
- Each symbol is serialised into one clock period: data pulses, then a clock pulse.
- Fixed phase offsets guarantee the adder's setup and A/B separation constraints by construction.
- Sits between the test/stimulus controller and the adder (or its pad drivers).

Parameters:
- PERIOD, 16: system cycles per adder clock period; must be >= SETUP+SEP+2.
- SETUP, 4: cycles from the B data pulse to the clock pulse.
- SEP, 2: cycles between the A pulse and the B pulse; must be >= 1.
- DEPTH, 4: symbol FIFO entries; power of 2, >= 2.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run the period sequencer.
- in_valid  in  1  symbol offered.
- in_a  in  1  A bit of the symbol.
- in_b  in  1  B bit of the symbol.
- in_ready  out  1  FIFO can accept a symbol.
- a_pulse  out  1  one-cycle A data pulse.
- b_pulse  out  1  one-cycle B data pulse.
- clk_pulse  out  1  one-cycle adder clock pulse.
- phase  out  $clog2(PERIOD)  current period phase.
- busy  out  1  FIFO non-empty or a symbol is in flight.
- sym_count  out  16  symbols transmitted; wraps 0xFFFF->0.

Behaviour:
- Reset, on any clock edge with reset=1 (including mid-period):
  - FIFO emptied; any in-flight symbol is discarded.
  - phase=0; state IDLE.
  - All pulses 0; busy=0; sym_count=0.
  - in_ready=1 from the first cycle after reset.
- FIFO handshake:
  - A push occurs when in_valid && in_ready.
  - in_ready = !full, a registered-flag function of the count only.
  - A pop in the same cycle does not make a full FIFO accept.
  - Push and pop in the same cycle on a non-full, non-empty FIFO leave the count unchanged.
  - Data ordering is strict FIFO.
- Sequencer states and transitions:
  - IDLE: phase held at 0. Go to RUN when enable=1.
  - RUN: phase increments each cycle and wraps PERIOD-1 -> 0. Go to IDLE at the wrap if enable=0. Deasserting enable mid-period always completes the current period.
- At phase 0 in RUN:
  - FIFO non-empty: pop into the symbol register (sa, sb) and set in_flight=1.
  - FIFO empty: the symbol is 00 and in_flight=0 (idle period).
- Pulse timing in RUN, all one cycle wide and registered:
  - a_pulse=sa at phase PERIOD-1-SETUP-SEP.
  - b_pulse=sb at phase PERIOD-1-SETUP.
  - clk_pulse=1 at phase PERIOD-1.
  - Pulses are 0 at every other phase and in IDLE.
- Symbol completion: at phase PERIOD-1 with in_flight=1, sym_count increments and in_flight clears in the same cycle.
- Symbol 11: both pulses are produced, exactly SEP apart.
- Symbol 00: no data pulses; the clock pulse is still emitted.
- busy = (count!=0) || in_flight.
- A symbol pushed into an empty FIFO during phase 0 is not popped until the next phase 0.

Optional Feature:
Macro HADD_TX_CLK_GATE_EN.
- Defined: clk_pulse is emitted only in periods with in_flight=1; idle periods produce no pulses at all.
- Undefined: clk_pulse is free-running, once per period in RUN, regardless of data.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset; enable=1; push a single symbol (1,0) while in IDLE -> first period: a_pulse at phase 9, no b_pulse, clk_pulse at phase 15; sym_count=1; busy=0 after phase 15.
2. Push (1,1) -> a_pulse at phase 9, b_pulse at phase 11 (separation exactly 2), clk_pulse at phase 15; all pulses exactly 1 cycle wide.
3. Hold in_valid=1 with enable=0 -> 4 pushes accepted, then in_ready=0. Set enable=1; a push attempted at the first pop cycle is refused. Symbols (0,1),(1,0),(1,1),(0,0) emerge in order over 4 periods; sym_count=4.
4. FIFO empty with enable=1 for 3 periods:
   - Macro undefined: clk_pulse at phases 15/31/47 and no data pulses.
   - Macro defined: no clk_pulse; sym_count unchanged.
5. Deassert enable at phase 5 with symbol (1,1) in flight -> pulses at 9/11/15 still produced; phase returns to 0 and holds there; busy=0.
6. Assert reset at phase 10, after a_pulse and before b_pulse, with 2 symbols queued -> no b_pulse and no clk_pulse; the cycle after reset: phase=0, busy=0, in_ready=1, sym_count=0.

Source files
------------

// File: rtl/hadd_pulse_tx.sv
// hadd_pulse_tx -- pulse-stream transmitter for a pulse-based half adder.
//
// Bit-pair symbols (A,B) arrive through a valid/ready handshake and are
// queued in a small FIFO. The period sequencer serialises one symbol per
// adder clock period of PERIOD system cycles:
//   phase PERIOD-1-SETUP-SEP : A data pulse (if A=1)
//   phase PERIOD-1-SETUP     : B data pulse (if B=1)
//   phase PERIOD-1           : adder clock pulse
// The fixed phase offsets give the adder its A/B separation and setup margin
// by construction.
//
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous, active-high
//   enable     run the period sequencer (a started period always completes)
//   in_valid   symbol offered; in_a / in_b are its bits
//   in_ready   FIFO not full (registered flag)
//   a_pulse    one-cycle A data pulse
//   b_pulse    one-cycle B data pulse
//   clk_pulse  one-cycle adder clock pulse
//   phase      current period phase
//   busy       FIFO non-empty or a symbol in flight
//   sym_count  symbols transmitted, wraps at 16 bits
//
// Build option: define HADD_TX_CLK_GATE_EN to suppress clk_pulse in periods
// that carry no symbol. Without it clk_pulse is free-running in RUN.

module hadd_pulse_tx #(
  parameter int PERIOD = 16,
  parameter int SETUP  = 4,
  parameter int SEP    = 2,
  parameter int DEPTH  = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      in_valid,
  input  logic                      in_a,
  input  logic                      in_b,
  output logic                      in_ready,
  output logic                      a_pulse,
  output logic                      b_pulse,
  output logic                      clk_pulse,
  output logic [$clog2(PERIOD)-1:0] phase,
  output logic                      busy,
  output logic [15:0]               sym_count
);

  localparam int PW = $clog2(PERIOD);
  localparam int AW = $clog2(DEPTH);

  localparam logic [PW-1:0] LAST_PH = PW'(PERIOD - 1);
  localparam logic [PW-1:0] A_PH    = PW'(PERIOD - 1 - SETUP - SEP);
  localparam logic [PW-1:0] B_PH    = PW'(PERIOD - 1 - SETUP);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] phase_nxt;

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          full_q;
  logic          fifo_empty;
  logic          push, pop;
  logic          period_start;

  logic          sa, sb;
  logic          in_flight;
  logic          a_nxt, b_nxt, clk_nxt;

  assign fifo_empty   = (count == '0);
  assign in_ready     = !full_q;
  assign push         = in_valid && !full_q;
  assign period_start = (state == RUN) && (phase == '0);
  assign pop          = period_start && !fifo_empty;
  assign busy         = !fifo_empty || in_flight;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + (AW + 1)'(1);
      2'b01:   count_nxt = count - (AW + 1)'(1);
      default: count_nxt = count;
    endcase
  end

  // Sequencer: IDLE parks at phase 0; RUN counts through a full period and
  // only checks enable at the wrap, so a started period is never truncated.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    case (state)
      IDLE: begin
        phase_nxt = '0;
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (phase == LAST_PH) begin
          phase_nxt = '0;
          if (!enable) state_nxt = IDLE;
        end else begin
          phase_nxt = phase + PW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        phase_nxt = '0;
      end
    endcase
  end

  // Pulses are registered from the next phase so each one is high exactly in
  // the cycle whose phase output equals its slot. All slots are non-zero, so
  // a match implies the sequencer stays in RUN.
  always_comb begin
    a_nxt = (phase_nxt == A_PH) && sa;
    b_nxt = (phase_nxt == B_PH) && sb;
`ifdef HADD_TX_CLK_GATE_EN
    clk_nxt = (phase_nxt == LAST_PH) && in_flight;
`else
    clk_nxt = (phase_nxt == LAST_PH);
`endif
  end

  // ---- Stage: FIFO storage and symbol register (data, no reset) ----
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {in_a, in_b};
    if (period_start) begin
      // An empty FIFO at period start yields an idle 00 period.
      if (fifo_empty) {sa, sb} <= 2'b00;
      else            {sa, sb} <= mem[rd_ptr];
    end
  end

  // ---- Stage: control registers ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full_q    <= 1'b0;
      in_flight <= 1'b0;
      a_pulse   <= 1'b0;
      b_pulse   <= 1'b0;
      clk_pulse <= 1'b0;
      sym_count <= '0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      count     <= count_nxt;
      full_q    <= (count_nxt == FULL_CNT);
      a_pulse   <= a_nxt;
      b_pulse   <= b_nxt;
      clk_pulse <= clk_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (period_start) begin
        in_flight <= !fifo_empty;
      end else if ((state == RUN) && (phase == LAST_PH) && in_flight) begin
        in_flight <= 1'b0;
        sym_count <= sym_count + 16'd1;
      end
    end
  end

endmodule
